// File: rtl/alu_arbiter.sv
// Round-robin arbiter that time-shares one ALU between NREQ requesters.
// Each accepted op drives the ALU from registers for EXEC_CYCLES, then its result is held for the owner.
module alu_arbiter #(
   parameter int NREQ        = 2,
   parameter int DATA_W      = 32,
   parameter int OP_W        = 6,
   parameter int EXEC_CYCLES = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NREQ-1:0]          req_valid,
   output logic [NREQ-1:0]          req_ready,
   input  logic [NREQ*DATA_W-1:0]   req_srca,
   input  logic [NREQ*DATA_W-1:0]   req_srcb,
   input  logic [NREQ*OP_W-1:0]     req_op,
   output logic [NREQ-1:0]          rsp_valid,
   input  logic [NREQ-1:0]          rsp_ready,
   output logic [DATA_W-1:0]        rsp_result,
   output logic                     rsp_zero,
   output logic                     busy,
   output logic [DATA_W-1:0]        alu_srca,
   output logic [DATA_W-1:0]        alu_srcb,
   output logic [OP_W-1:0]          alu_op,
   input  logic [DATA_W-1:0]        alu_result,
   input  logic                     alu_zero
);

   localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   last_q, last_d;
   logic [IDX_W-1:0]   owner_q, owner_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [DATA_W-1:0]  srca_q, srca_d;
   logic [DATA_W-1:0]  srcb_q, srcb_d;
   logic [OP_W-1:0]    op_q, op_d;
   logic [DATA_W-1:0]  res_q, res_d;
   logic               zero_q, zero_d;

   logic [IDX_W-1:0]   win_idx;
   logic               win_found;
   logic [NREQ-1:0]    grant;

   // Scan starts just after the last owner so a held request wins within NREQ-1 grants.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      for (int k = 1; k <= NREQ; k++) begin
         if (!win_found && req_valid[(int'(last_q) + k) % NREQ]) begin
            win_found = 1'b1;
            win_idx   = IDX_W'((int'(last_q) + k) % NREQ);
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      owner_d   = owner_q;
      cnt_d     = cnt_q;
      srca_d    = srca_q;
      srcb_d    = srcb_q;
      op_d      = op_q;
      res_d     = res_q;
      zero_d    = zero_q;
      grant     = '0;
      rsp_valid = '0;
      case (state_q)
         IDLE: begin
            if (win_found) begin
               grant[win_idx] = 1'b1;
               owner_d        = win_idx;
               srca_d         = req_srca[win_idx*DATA_W +: DATA_W];
               srcb_d         = req_srcb[win_idx*DATA_W +: DATA_W];
               op_d           = req_op[win_idx*OP_W +: OP_W];
               cnt_d          = CNT_W'(EXEC_CYCLES - 1);
               state_d        = EXEC;
            end
         end
         EXEC: begin
            if (cnt_q == '0) begin
               res_d   = alu_result;
               zero_d  = alu_zero;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         RESP: begin
            rsp_valid[owner_q] = 1'b1;
            if (rsp_ready[owner_q]) begin
               last_d  = owner_q;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         last_q  <= IDX_W'(NREQ - 1);
         owner_q <= '0;
         cnt_q   <= '0;
         srca_q  <= '0;
         srcb_q  <= '0;
         op_q    <= '0;
         res_q   <= '0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         owner_q <= owner_d;
         cnt_q   <= cnt_d;
         srca_q  <= srca_d;
         srcb_q  <= srcb_d;
         op_q    <= op_d;
         res_q   <= res_d;
         zero_q  <= zero_d;
      end
   end

   // Grant is combinational from req_valid, so it is masked while reset is asserted.
   assign req_ready  = grant & {NREQ{rst_n}};
   assign busy       = (state_q != IDLE);
   assign alu_srca   = srca_q;
   assign alu_srcb   = srcb_q;
   assign alu_op     = op_q;
   assign rsp_result = res_q;
   assign rsp_zero   = zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: two instances (EXEC_CYCLES 1 and 3) share one stimulus path selected by sel,
// checked cycle by cycle against a transaction-timeline model of the arbiter.
module tb_alu_arbiter;

   localparam int NREQ = 2;
   localparam int DW   = 32;
   localparam int OW   = 6;
   localparam logic [OW-1:0] OP_AND = 6'd0;
   localparam logic [OW-1:0] OP_OR  = 6'd1;
   localparam logic [OW-1:0] OP_ADD = 6'd2;
   localparam logic [OW-1:0] OP_SUB = 6'd6;

   logic clk = 1'b0;
   logic rst_n;
   logic sel;
   always #5 clk = ~clk;

   logic [NREQ-1:0]    d_vld, d_rrdy;
   logic [NREQ*DW-1:0] d_a, d_b;
   logic [NREQ*OW-1:0] d_op;

   logic [NREQ-1:0] a_vld, a_rrdy, a_rdy, a_rv;
   logic [DW-1:0]   a_res, a_sa, a_sb, a_ar;
   logic [OW-1:0]   a_op;
   logic            a_z, a_busy, a_az;

   logic [NREQ-1:0] b_vld, b_rrdy, b_rdy, b_rv;
   logic [DW-1:0]   b_res, b_sa, b_sb, b_ar;
   logic [OW-1:0]   b_op;
   logic            b_z, b_busy, b_az;

   logic [NREQ-1:0] o_rdy, o_rv;
   logic [DW-1:0]   o_res, o_sa, o_sb;
   logic [OW-1:0]   o_op;
   logic            o_z, o_busy;

   function automatic logic [DW-1:0] alu_f(input logic [DW-1:0] x, input logic [DW-1:0] y,
                                           input logic [OW-1:0] op);
      case (op)
         OP_AND:  return x & y;
         OP_OR:   return x | y;
         OP_ADD:  return x + y;
         OP_SUB:  return x - y;
         default: return x ^ y;
      endcase
   endfunction

   assign a_vld  = sel ? '0 : d_vld;
   assign a_rrdy = sel ? '0 : d_rrdy;
   assign b_vld  = sel ? d_vld  : '0;
   assign b_rrdy = sel ? d_rrdy : '0;
   assign a_ar   = alu_f(a_sa, a_sb, a_op);
   assign a_az   = (a_ar == '0);
   assign b_ar   = alu_f(b_sa, b_sb, b_op);
   assign b_az   = (b_ar == '0);

   assign o_rdy  = sel ? b_rdy  : a_rdy;
   assign o_rv   = sel ? b_rv   : a_rv;
   assign o_res  = sel ? b_res  : a_res;
   assign o_z    = sel ? b_z    : a_z;
   assign o_busy = sel ? b_busy : a_busy;
   assign o_sa   = sel ? b_sa   : a_sa;
   assign o_sb   = sel ? b_sb   : a_sb;
   assign o_op   = sel ? b_op   : a_op;

   alu_arbiter #(.NREQ(NREQ), .DATA_W(DW), .OP_W(OW), .EXEC_CYCLES(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .req_valid(a_vld), .req_ready(a_rdy),
      .req_srca(d_a), .req_srcb(d_b), .req_op(d_op),
      .rsp_valid(a_rv), .rsp_ready(a_rrdy), .rsp_result(a_res), .rsp_zero(a_z), .busy(a_busy),
      .alu_srca(a_sa), .alu_srcb(a_sb), .alu_op(a_op), .alu_result(a_ar), .alu_zero(a_az));

   alu_arbiter #(.NREQ(NREQ), .DATA_W(DW), .OP_W(OW), .EXEC_CYCLES(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .req_valid(b_vld), .req_ready(b_rdy),
      .req_srca(d_a), .req_srcb(d_b), .req_op(d_op),
      .rsp_valid(b_rv), .rsp_ready(b_rrdy), .rsp_result(b_res), .rsp_zero(b_z), .busy(b_busy),
      .alu_srca(b_sa), .alu_srcb(b_sb), .alu_op(b_op), .alu_result(b_ar), .alu_zero(b_az));

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Requester-side pending ops (held until granted)
   logic            p_vld [NREQ];
   logic [DW-1:0]   p_a   [NREQ];
   logic [DW-1:0]   p_b   [NREQ];
   logic [OW-1:0]   p_op  [NREQ];

   // Model: owner (-1 = none), cycles since accept, last owner served, held register images
   int            m_own, m_age, m_last, m_exec;
   logic [DW-1:0] m_a, m_b, m_res;
   logic [OW-1:0] m_op;
   logic          m_z;
   int            g[$];

   task automatic model_reset();
      m_own = -1; m_age = 0; m_last = NREQ - 1;
      m_a = '0; m_b = '0; m_op = '0; m_res = '0; m_z = 1'b0;
   endtask

   task automatic clear_pending();
      for (int i = 0; i < NREQ; i++) begin
         p_vld[i] = 1'b0; p_a[i] = '0; p_b[i] = '0; p_op[i] = '0;
      end
   endtask

   task automatic set_op(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [OW-1:0] op);
      p_vld[i] = 1'b1; p_a[i] = a; p_b[i] = b; p_op[i] = op;
   endtask

   task automatic new_op(input int i);
      logic [DW-1:0] a, b;
      logic [OW-1:0] op;
      a = $urandom;
      b = ($urandom_range(3, 0) == 0) ? a : $urandom;
      case ($urandom_range(4, 0))
         0:       op = OP_AND;
         1:       op = OP_OR;
         2:       op = OP_ADD;
         3:       op = OP_SUB;
         default: op = 6'd7;
      endcase
      set_op(i, a, b, op);
   endtask

   task automatic drive();
      for (int i = 0; i < NREQ; i++) begin
         d_vld[i]           = p_vld[i];
         d_a[i*DW +: DW]    = p_a[i];
         d_b[i*DW +: DW]    = p_b[i];
         d_op[i*OW +: OW]   = p_op[i];
      end
   endtask

   function automatic int pick();
      for (int k = 1; k <= NREQ; k++)
         if (p_vld[(m_last + k) % NREQ]) return (m_last + k) % NREQ;
      return -1;
   endfunction

   // One clock cycle: entered and left at posedge+1.
   task automatic step(input bit rnd);
      int pk;
      logic [NREQ-1:0] exp_rdy, exp_rv;
      @(negedge clk);
      pk      = (m_own < 0) ? pick() : -1;
      exp_rdy = '0;
      exp_rv  = '0;
      if (pk >= 0) exp_rdy[pk] = 1'b1;
      if (m_own >= 0 && m_age > m_exec) exp_rv[m_own] = 1'b1;
      if (o_rdy == 2'b01) g.push_back(0);
      else if (o_rdy == 2'b10) g.push_back(1);
      else if (o_rdy != '0) g.push_back(9);
      chk("req_ready", o_rdy, exp_rdy);
      chk("rsp_valid", o_rv, exp_rv);
      chk("busy", o_busy, (m_own >= 0));
      chk("alu_srca", o_sa, m_a);
      chk("alu_srcb", o_sb, m_b);
      chk("alu_op", o_op, m_op);
      chk("rsp_result", o_res, m_res);
      chk("rsp_zero", o_z, m_z);
      if (pk >= 0) begin
         m_own = pk; m_age = 1;
         m_a = p_a[pk]; m_b = p_b[pk]; m_op = p_op[pk];
      end else if (m_own >= 0 && m_age <= m_exec) begin
         m_age++;
         if (m_age > m_exec) begin
            m_res = alu_f(m_a, m_b, m_op);
            m_z   = (m_res == '0);
         end
      end else if (m_own >= 0 && d_rrdy[m_own]) begin
         m_last = m_own;
         m_own  = -1;
      end
      @(posedge clk);
      #1;
      if (pk >= 0) p_vld[pk] = 1'b0;
      if (rnd) begin
         for (int i = 0; i < NREQ; i++)
            if (!p_vld[i] && $urandom_range(1, 0) == 1) new_op(i);
         d_rrdy = NREQ'($urandom);
      end
      drive();
   endtask

   task automatic chk_zero();
      chk("rst req_ready", o_rdy, 0);
      chk("rst rsp_valid", o_rv, 0);
      chk("rst busy", o_busy, 0);
      chk("rst alu_srca", o_sa, 0);
      chk("rst alu_srcb", o_sb, 0);
      chk("rst alu_op", o_op, 0);
      chk("rst rsp_result", o_res, 0);
      chk("rst rsp_zero", o_z, 0);
   endtask

   // Asserted at posedge+1 so the async path is seen between edges.
   task automatic reset_all();
      rst_n = 1'b0;
      clear_pending();
      drive();
      d_rrdy = '0;
      model_reset();
      #1;
      chk_zero();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   int exp_g [4];

   initial begin
      sel = 1'b0; m_exec = 1; d_rrdy = '0;
      d_vld = '0; d_a = '0; d_b = '0; d_op = '0;
      clear_pending(); drive(); model_reset();
      rst_n = 1'b1;
      #1 rst_n = 1'b0;

      // Both requesters valid while in reset: nothing may be granted
      set_op(0, 32'd1, 32'd2, OP_ADD);
      set_op(1, 32'd10, 32'd4, OP_SUB);
      drive();
      d_rrdy = '1;
      repeat (2) @(posedge clk);
      #1;
      chk_zero();
      rst_n = 1'b1;

      // Alternating grants with both requesters continuously valid
      for (int c = 0; c < 13; c++) begin
         step(0);
         if (!p_vld[0]) set_op(0, 32'd1, 32'd2, OP_ADD);
         if (!p_vld[1]) set_op(1, 32'd10, 32'd4, OP_SUB);
         drive();
      end
      exp_g = '{0, 1, 0, 1};
      for (int k = 0; k < 4; k++)
         chk("t2 grant order", (k < g.size()) ? g[k] : 99, exp_g[k]);

      // Single ADD: ready at T, busy T+1, response T+2
      reset_all();
      set_op(0, 32'd5, 32'd7, OP_ADD);
      drive();
      step(0);
      step(0);
      #2;
      chk("t1 rsp_valid", o_rv, 2'b01);
      chk("t1 result", o_res, 32'd12);
      chk("t1 zero", o_z, 1'b0);
      d_rrdy = 2'b01;
      step(0);

      // SUB with equal operands raises Zero for requester 1
      d_rrdy = '1;
      set_op(1, 32'd9, 32'd9, OP_SUB);
      drive();
      step(0);
      step(0);
      #2;
      chk("t3 rsp_valid", o_rv, 2'b10);
      chk("t3 result", o_res, 32'd0);
      chk("t3 zero", o_z, 1'b1);
      step(0);

      // Owner stalls RESP while req1 waits; non-owner rsp_ready must be ignored
      d_rrdy = 2'b10;
      set_op(0, 32'h100, 32'h23, OP_ADD);
      drive();
      step(0);
      step(0);
      set_op(1, 32'd7, 32'd3, OP_SUB);
      drive();
      repeat (5) step(0);
      #2;
      chk("t4 held result", o_res, 32'h123);
      chk("t4 held valid", o_rv, 2'b01);
      d_rrdy = 2'b01;
      step(0);
      #2;
      chk("t4 regrant", o_rdy, 2'b10);
      d_rrdy = '1;
      repeat (3) step(0);

      // Reset in the middle of EXEC discards the op
      set_op(0, 32'hAAAA, 32'd1, OP_ADD);
      drive();
      d_rrdy = '1;
      step(0);
      reset_all();
      d_rrdy = '1;
      step(0);
      step(0);
      set_op(1, 32'h1234, 32'h11, OP_ADD);
      drive();
      step(0);
      step(0);
      #2;
      chk("t5 rsp_valid", o_rv, 2'b10);
      chk("t5 result", o_res, 32'h1245);
      step(0);

      repeat (400) step(1);

      // Switch to the EXEC_CYCLES=3 instance
      reset_all();
      sel = 1'b1;
      m_exec = 3;
      set_op(0, 32'hF0, 32'h0F, OP_OR);
      drive();
      step(0);
      repeat (3) step(0);
      #2;
      chk("t6 rsp_valid", o_rv, 2'b01);
      chk("t6 result", o_res, 32'hFF);
      d_rrdy = 2'b01;
      step(0);

      repeat (300) step(1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
